// File: rtl/inst_fetch_queue_if.sv
// Fetch-engine bus bundle: the instruction-memory request/ack channel and the
// valid/ready channel toward the IF/ID pipe register.
interface inst_fetch_queue_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_instr_i;
    logic        id_valid_o;
    logic        id_ready_i;
    logic [31:0] id_instr_o;
    logic [31:0] id_pc_add_4_o;

    modport master (
        output imem_req_o, imem_addr_o,
        input  imem_ack_i, imem_instr_i,
        output id_valid_o, id_instr_o, id_pc_add_4_o,
        input  id_ready_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o,
        output imem_ack_i, imem_instr_i,
        input  id_valid_o, id_instr_o, id_pc_add_4_o,
        output id_ready_i
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// IF-stage fetch engine: one outstanding request to a variable-latency
// instruction memory, a DEPTH-entry prefetch queue, and redirect/flush handling.
module inst_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic                      clk_i,
    input  logic                      rst_n,
    input  logic                      redirect_i,
    input  logic [31:0]               redirect_pc_i,
    inst_fetch_queue_if.master        bus
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_DISCARD
    } state_t;

    state_t            state, state_nxt;
    logic [31:0]       fetch_pc;
    logic [31:0]       fetch_addr;
    logic [31:0]       pc_plus_4;
    logic [31:0]       discard_addr;
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [31:0]       instr_mem [DEPTH];
    logic [31:0]       pc4_mem   [DEPTH];

    logic req;
    logic ack_fire;
    logic push;
    logic pop;
    logic not_full;
    logic head_valid;

    assign fetch_addr = {fetch_pc[31:2], 2'b00};
    assign pc_plus_4  = fetch_pc + 32'd4;
    assign not_full   = (count != CNT_W'(DEPTH));
    assign head_valid = (count != '0);

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        req       = 1'b0;
        case (state)
            S_FETCH: begin
                // rst_n gate keeps the request low while reset is held.
                req = rst_n && not_full && !redirect_i;
                if (req && !bus.imem_ack_i) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                req = 1'b1;
                if (bus.imem_ack_i)  state_nxt = S_FETCH;
                else if (redirect_i) state_nxt = S_DISCARD;
            end
            S_DISCARD: begin
                req = 1'b1;
                if (bus.imem_ack_i) state_nxt = S_FETCH;
            end
            default: state_nxt = S_FETCH;
        endcase
    end

    // Abandoned responses and anything arriving alongside a redirect are dropped.
    assign ack_fire = req && bus.imem_ack_i;
    assign push     = ack_fire && (state != S_DISCARD) && !redirect_i;
    assign pop      = head_valid && bus.id_ready_i && !redirect_i;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_FETCH;
            fetch_pc     <= RESET_PC;
            discard_addr <= '0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
        end else begin
            state <= state_nxt;
            if (redirect_i) begin
                fetch_pc <= redirect_pc_i;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
            end else begin
                if (push) begin
                    fetch_pc <= pc_plus_4;
                    wr_ptr   <= wr_ptr + PTR_W'(1);
                end
                if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
                count <= count + CNT_W'(push) - CNT_W'(pop);
            end
            if (state == S_WAIT && redirect_i && !bus.imem_ack_i)
                discard_addr <= fetch_addr;
        end
    end

    // NOTE: queue storage has no reset; the head is only exposed while count != 0.
    always_ff @(posedge clk_i) begin
        if (push) begin
            instr_mem[wr_ptr] <= bus.imem_instr_i;
            pc4_mem[wr_ptr]   <= pc_plus_4;
        end
    end

    assign bus.imem_req_o    = req;
    assign bus.imem_addr_o   = (state == S_DISCARD) ? discard_addr : fetch_addr;
    assign bus.id_valid_o    = head_valid;
    assign bus.id_instr_o    = head_valid ? instr_mem[rd_ptr] : '0;
    assign bus.id_pc_add_4_o = head_valid ? pc4_mem[rd_ptr]   : '0;

endmodule
